// File: rtl/alu_div_unit_pkg.sv
// Shared definitions for the multicycle divider: widths, FSM encoding and a
// conditional two's-complement negate used for both operand magnitudes and result sign fix.
package alu_div_unit_pkg;

  localparam int WIDTH     = 32;
  localparam int CNT_W     = 6;
  localparam int ITER_LAST = WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    logic [WIDTH-1:0] res;
    if (neg) begin
      res = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_div_unit_if.sv
// Request/result bundle between the execute stage and the divider.
interface alu_div_unit_if;

  logic                                 ctrl_DIV;
  logic                                 ctrl_signed;
  logic [alu_div_unit_pkg::WIDTH-1:0]   data_operandA;
  logic [alu_div_unit_pkg::WIDTH-1:0]   data_operandB;
  logic [alu_div_unit_pkg::WIDTH-1:0]   data_result;
  logic [alu_div_unit_pkg::WIDTH-1:0]   data_remainder;
  logic                                 data_exception;
  logic                                 data_resultRDY;
  logic                                 busy;

  modport master (
    output ctrl_DIV, ctrl_signed, data_operandA, data_operandB,
    input  data_result, data_remainder, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_DIV, ctrl_signed, data_operandA, data_operandB,
    output data_result, data_remainder, data_exception, data_resultRDY, busy
  );

endinterface

// File: rtl/alu_div_unit_div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted
// partial remainder, keeping the difference only when it does not go negative.
module div_step
  import alu_div_unit_pkg::*;
(
  input  logic [WIDTH:0]   i_r_shifted,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_next_r,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_diff;

  assign w_diff   = i_r_shifted + ~{1'b0, i_divisor} + {{WIDTH{1'b0}}, 1'b1};
  // A clear sign bit at WIDTH+1 bits means the divisor fit into the partial remainder.
  assign o_q_bit  = ~w_diff[WIDTH];
  assign o_next_r = o_q_bit ? w_diff[WIDTH-1:0] : i_r_shifted[WIDTH-1:0];

endmodule

// File: rtl/alu_div_unit.sv
// Multicycle MIPS div/divu: one quotient bit per clock on operand magnitudes,
// then a single fix-up cycle applies signs and publishes quotient (LO) and remainder (HI).
module alu_div_unit
  import alu_div_unit_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  alu_div_unit_if.slave bus
);

  div_state_e        r_state;
  div_state_e        w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_rem;
  logic [WIDTH-1:0]  r_quo;
  logic [WIDTH-1:0]  r_divisor;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_zero;
  logic [WIDTH-1:0]  r_result;
  logic [WIDTH-1:0]  r_remainder;
  logic              r_exception;
  logic              r_rdy;
  logic              r_busy;

  logic [WIDTH:0]    w_r_shifted;
  logic [WIDTH-1:0]  w_next_r;
  logic              w_q_bit;
  logic [WIDTH-1:0]  w_abs_a;
  logic [WIDTH-1:0]  w_abs_b;
  logic              w_b_zero;
  logic              w_last;

  assign w_abs_a     = neg_if(bus.data_operandA, bus.ctrl_signed & bus.data_operandA[WIDTH-1]);
  assign w_abs_b     = neg_if(bus.data_operandB, bus.ctrl_signed & bus.data_operandB[WIDTH-1]);
  assign w_b_zero    = (bus.data_operandB == {WIDTH{1'b0}});
  assign w_last      = (r_cnt == CNT_W'(ITER_LAST));
  assign w_r_shifted = {r_rem, r_quo[WIDTH-1]};

  div_step u_div_step (
    .i_r_shifted (w_r_shifted),
    .i_divisor   (r_divisor),
    .o_next_r    (w_next_r),
    .o_q_bit     (w_q_bit)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: a zero divisor skips the iterations and goes straight to fix-up.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.ctrl_DIV) begin
          w_next_state = w_b_zero ? ST_FIX : ST_ITER;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (w_last) begin
          w_next_state = ST_FIX;
        end else begin
          w_next_state = ST_ITER;
        end
      end
      ST_FIX:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Datapath, counter and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= {CNT_W{1'b0}};
      r_rem       <= {WIDTH{1'b0}};
      r_quo       <= {WIDTH{1'b0}};
      r_divisor   <= {WIDTH{1'b0}};
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_zero      <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_remainder <= {WIDTH{1'b0}};
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.ctrl_DIV) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_rem     <= {WIDTH{1'b0}};
            // On divide-by-zero the raw dividend is parked here for the HI result.
            r_quo     <= w_b_zero ? bus.data_operandA : w_abs_a;
            r_divisor <= w_abs_b;
            r_neg_q   <= bus.ctrl_signed & (bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1]);
            r_neg_r   <= bus.ctrl_signed & bus.data_operandA[WIDTH-1];
            r_zero    <= w_b_zero;
            r_busy    <= 1'b1;
          end
        end
        ST_ITER: begin
          r_rem <= w_next_r;
          r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_FIX: begin
          r_rdy  <= 1'b1;
          r_busy <= 1'b0;
          if (r_zero) begin
            r_result    <= {WIDTH{1'b0}};
            r_remainder <= r_quo;
            r_exception <= 1'b1;
          end else begin
            r_result    <= neg_if(r_quo, r_neg_q);
            r_remainder <= neg_if(r_rem, r_neg_r);
            r_exception <= 1'b0;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_remainder = r_remainder;
  assign bus.data_exception = r_exception;
  assign bus.data_resultRDY = r_rdy;
  assign bus.busy           = r_busy;

endmodule

// File: tb/tb_alu_div_unit.sv
// Directed bench for alu_div_unit: a vector table for div/divu results and
// latency, plus hand sequences for busy-ignore, mid-operation reset and back-to-back issue.
module tb_alu_div_unit;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  alu_div_unit_if u_if ();

  alu_div_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        exc;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive a request for one edge (the capture edge E0), then scramble operands.
  task automatic start_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(posedge clock); #1;
    u_if.ctrl_DIV      = 1'b1;
    u_if.ctrl_signed   = s;
    u_if.data_operandA = a;
    u_if.data_operandB = b;
    @(posedge clock); #1;
    u_if.ctrl_DIV      = 1'b0;
    u_if.ctrl_signed   = ~s;
    u_if.data_operandA = 32'hA5A5_A5A5;
    u_if.data_operandB = 32'h5A5A_5A5A;
    chk("busy_after_capture", {31'd0, u_if.busy}, 32'd1);
  endtask

  // Count edges after capture until rdy, bounded; busy must stay high meanwhile.
  task automatic wait_rdy(input int already, output int lat);
    logic got;
    logic busy_ok;
    got     = 1'b0;
    busy_ok = 1'b1;
    lat     = already;
    while (!got && lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (u_if.data_resultRDY) got = 1'b1;
      else if (!u_if.busy) busy_ok = 1'b0;
    end
    chk("busy_held_until_rdy", {31'd0, busy_ok}, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [31:0] q, input logic [31:0] r,
                              input logic exc);
    chk({tag, "_result"},    u_if.data_result,    q);
    chk({tag, "_remainder"}, u_if.data_remainder, r);
    chk({tag, "_exception"}, {31'd0, u_if.data_exception}, {31'd0, exc});
    chk({tag, "_busy_at_rdy"}, {31'd0, u_if.busy}, 32'd0);
    @(posedge clock); #1;
    chk({tag, "_rdy_one_cycle"}, {31'd0, u_if.data_resultRDY}, 32'd0);
    chk({tag, "_result_hold"},   u_if.data_result, q);
  endtask

  initial begin
    int   lat;
    int   seen;

    reset_n            = 1'b1;
    u_if.ctrl_DIV      = 1'b0;
    u_if.ctrl_signed   = 1'b0;
    u_if.data_operandA = 32'd0;
    u_if.data_operandB = 32'd0;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_result",    u_if.data_result,    32'd0);
    chk("reset_remainder", u_if.data_remainder, 32'd0);
    chk("reset_exception", {31'd0, u_if.data_exception}, 32'd0);
    chk("reset_rdy",       {31'd0, u_if.data_resultRDY}, 32'd0);
    chk("reset_busy",      {31'd0, u_if.busy}, 32'd0);
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;

    vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 33};
    vecs[1]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33};
    vecs[2]  = '{32'h0000_1234, 32'd0,         1'b0, 32'd0,         32'h0000_1234, 1'b1, 1};
    vecs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0, 33};
    vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 1'b0, 33};
    vecs[5]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0, 33};
    vecs[6]  = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3,         32'hFFFF_FFFF, 1'b0, 33};
    vecs[7]  = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0,         1'b0, 33};
    vecs[8]  = '{32'd5,         32'd10,        1'b0, 32'd0,         32'd5,         1'b0, 33};
    vecs[9]  = '{32'hFFFF_FFF9, 32'd0,         1'b1, 32'd0,         32'hFFFF_FFF9, 1'b1, 1};
    vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1,         32'd0,         1'b0, 33};
    vecs[11] = '{32'hDEAD_BEEF, 32'h0000_0010, 1'b0, 32'h0DEA_DBEE, 32'h0000_000F, 1'b0, 33};
    vecs[12] = '{32'hFFFF_FF9C, 32'd7,         1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33};

    for (int i = 0; i < 13; i++) begin
      start_div(vecs[i].a, vecs[i].b, vecs[i].s);
      wait_rdy(0, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].exc);
    end

    // Second request during iteration 10 must be dropped.
    start_div(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clock);
    #1;
    u_if.ctrl_DIV      = 1'b1;
    u_if.data_operandA = 32'd9;
    u_if.data_operandB = 32'd3;
    @(posedge clock); #1;
    u_if.ctrl_DIV = 1'b0;
    wait_rdy(10, lat);
    chk("busy_ignore_latency", lat, 33);
    check_result("busy_ignore", 32'd14, 32'd2, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("busy_ignore_no_queue", {31'd0, u_if.busy}, 32'd0);

    // Asynchronous reset in the middle of iteration 20.
    start_div(32'd100, 32'd7, 1'b0);
    repeat (19) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_result",    u_if.data_result,    32'd0);
    chk("midreset_remainder", u_if.data_remainder, 32'd0);
    chk("midreset_busy",      {31'd0, u_if.busy}, 32'd0);
    chk("midreset_rdy",       {31'd0, u_if.data_resultRDY}, 32'd0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (u_if.data_resultRDY) seen++;
    end
    chk("midreset_no_rdy", seen, 32'd0);
    start_div(32'd9, 32'd3, 1'b0);
    wait_rdy(0, lat);
    chk("restart_latency", lat, 33);
    check_result("restart", 32'd3, 32'd0, 1'b0);

    // New request presented in the rdy cycle is accepted immediately.
    start_div(32'd100, 32'd7, 1'b0);
    wait_rdy(0, lat);
    chk("b2b_first_latency", lat, 33);
    chk("b2b_first_result", u_if.data_result, 32'd14);
    u_if.ctrl_DIV      = 1'b1;
    u_if.ctrl_signed   = 1'b0;
    u_if.data_operandA = 32'd9;
    u_if.data_operandB = 32'd3;
    @(posedge clock); #1;
    u_if.ctrl_DIV      = 1'b0;
    u_if.data_operandA = 32'hA5A5_A5A5;
    chk("b2b_busy_after_capture", {31'd0, u_if.busy}, 32'd1);
    chk("b2b_rdy_cleared",        {31'd0, u_if.data_resultRDY}, 32'd0);
    wait_rdy(0, lat);
    chk("b2b_second_latency", lat, 33);
    check_result("b2b_second", 32'd3, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
